rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Shares the register file's single write port among `NUM_SRC` writeback requesters, such as the ALU, load and multiply/divide paths, using round-robin arbitration and a registered write stage. It also keeps a per-register pending scoreboard: issue marks a destination busy, and commit clears it. It sits between the pipeline's writeback producers and `reg_file`. Its `pending` output feeds the decode-stage hazard/stall logic.

## Interface
Parameters:
- `REG_WIDTH`, 64, data width of one architectural register.
- `REG_COUNT`, 32, number of registers; `AW = $clog2(REG_COUNT)`.
- `NUM_SRC`, 3, number of writeback requesters (2..8).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `src_valid`  in  `NUM_SRC`  requester i has a writeback pending.
- `src_addr`  in  `NUM_SRC*AW`  destination register; slice i is `[i*AW +: AW]`.
- `src_data`  in  `NUM_SRC*REG_WIDTH`  write data; slice i is `[i*REG_WIDTH +: REG_WIDTH]`.
- `src_ready`  out  `NUM_SRC`  grant; one-hot or zero; combinational from `src_valid` and the arbiter pointer.
- `issue_valid`  in  1  an instruction with destination `issue_rd` is issued this cycle.
- `issue_rd`  in  AW  destination of the issued instruction.
- `rf_we`  out  1  registered write enable to `reg_file.writeEnable`.
- `rf_waddr`  out  AW  registered write address.
- `rf_wdata`  out  `REG_WIDTH`  registered write data.
- `pending`  out  `REG_COUNT`  scoreboard; bit r set means register r awaits writeback.

## Operation
- Handshake: a transfer occurs on a cycle where `src_valid[i] && src_ready[i]`. A requester holds valid, addr and data stable until it is accepted; there is no other backpressure.
- At most one grant per cycle. If any `src_valid` is high, exactly one `src_ready` is high in the same cycle.
- Round-robin search:
  - The search starts at `(last+1) mod NUM_SRC` and the first valid requester wins.
  - `last` updates to the winner only on a transfer.
  - `last` resets to `NUM_SRC-1`, so src0 has first priority after reset.
- Write stage, on the edge following a transfer:
  - `rf_waddr <= addr` and `rf_wdata <= data`.
  - `rf_we <= (addr != 0)`. A write to x0 is accepted and dropped.
  - With no transfer, `rf_we <= 0` and `rf_waddr`/`rf_wdata` hold their previous values.
- Scoreboard:
  - On each edge, `pending[issue_rd]` is set if `issue_valid && issue_rd != 0`.
  - `pending[rf_waddr]` is cleared if `rf_we`.
  - If set and clear target the same register in the same cycle, set wins, because the newer instruction owns the register.
  - `pending[0]` is constant 0.
- Writing a register whose pending bit is clear is legal. It performs the write and the bit stays clear.

## Timing
- Reset values: `rf_we=0`, `rf_waddr=0`, `rf_wdata=0`, `pending=0`, `src_ready=0` (no valids can be granted during reset), `last=NUM_SRC-1`.
- Latency:
  - Transfer in cycle N gives `rf_we=1` during cycle N+1, and the register file updates at the end of N+1.
  - `pending` clears at that same edge, so the first cycle it reads 0 is N+2.
  - `reg_file`'s bypass covers readers during cycle N+1.
- Issue in cycle N gives `pending` set from cycle N+1.
- Throughput is one writeback per cycle. With all sources continuously valid, each source is granted every `NUM_SRC` cycles.
- Reset mid-operation: an in-flight write is discarded and all pending bits clear immediately (asynchronous).

## Configuration
- `RF_WB_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, lowest index wins; `last` is not implemented.
  - Undefined (default): round-robin as described above.
- Handshake, write stage and scoreboard behaviour are identical in both builds.

## Test plan
- Reset, then src0 valid with addr=5 and data=0xDEAD: `src_ready=001` in cycle 0, then `rf_we=1`, `rf_waddr=5`, `rf_wdata=0xDEAD` in cycle 1, then `rf_we=0` in cycle 2.
- All three sources held valid for 6 cycles (round-robin build): grant order src0, src1, src2, src0, src1, src2. With the macro defined, all 6 grants go to src0.
- src1 valid with addr=0: `src_ready[1]=1`, `rf_we` stays 0, and `pending` is unchanged.
- Issue rd=7, then 3 cycles later src2 writes rd=7: `pending[7]=1` from the cycle after issue until it clears the edge after `rf_we`.
- In the cycle `rf_we=1` with `rf_waddr=9`, assert issue rd=9: `pending[9]` remains 1. A separate issue of rd=0 never sets `pending[0]`.
- Assert `rst` asynchronously while `rf_we=1` and `pending=0x0000_0F00`: all outputs go to 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//   Shares the register file's single write port among NUM_SRC writeback
//   requesters. It has a round-robin arbiter, a registered write stage and a
//   per-register pending scoreboard that feeds decode hazard detection.
//
//   Optional build macro: RF_WB_ARB_FIXED_PRIO_EN. When it is defined, the
//   arbiter uses fixed priority (lowest index wins) and has no `last` state.
//
// Ports
//   clk, rst     : clock (rising edge) and asynchronous active-high reset
//   src_valid    : per-requester writeback request
//   src_addr     : packed destination registers, slice i = [i*AW +: AW]
//   src_data     : packed write data, slice i = [i*REG_WIDTH +: REG_WIDTH]
//   src_ready    : combinational one-hot grant (zero while in reset)
//   issue_valid  : an instruction writing issue_rd is issued this cycle
//   issue_rd     : destination of the issued instruction
//   rf_we        : registered write enable to the register file
//   rf_waddr     : registered write address
//   rf_wdata     : registered write data
//   pending      : scoreboard, bit r set = register r awaits writeback
//
// Handshake: a transfer happens in any cycle where src_valid[i] && src_ready[i].
//   A requester keeps valid, addr and data stable until it is accepted.
//   There is no other backpressure.
module rf_wb_arbiter #(
  parameter int REG_WIDTH = 64,
  parameter int REG_COUNT = 32,
  parameter int NUM_SRC   = 3,
  localparam int AW       = $clog2(REG_COUNT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC*AW-1:0]         src_addr,
  input  logic [NUM_SRC*REG_WIDTH-1:0]  src_data,
  output logic [NUM_SRC-1:0]            src_ready,
  input  logic                          issue_valid,
  input  logic [AW-1:0]                 issue_rd,
  output logic                          rf_we,
  output logic [AW-1:0]                 rf_waddr,
  output logic [REG_WIDTH-1:0]          rf_wdata,
  output logic [REG_COUNT-1:0]          pending
);

  logic [NUM_SRC-1:0]   grant;
  logic                 found;
  logic                 xfer;
  logic [AW-1:0]        sel_addr;
  logic [REG_WIDTH-1:0] sel_data;
  logic [REG_COUNT-1:0] pend_next;

`ifdef RF_WB_ARB_FIXED_PRIO_EN
  // Fixed priority: the lowest-indexed valid requester wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!found && src_valid[i]) begin
        found    = 1'b1;
        grant[i] = 1'b1;
      end
    end
  end
`else
  localparam int LW = $clog2(NUM_SRC);

  logic [LW-1:0] last;
  logic [LW-1:0] win;

  // Round-robin: the search starts just after the last winner.
  always_comb begin
    grant = '0;
    found = 1'b0;
    win   = last;
    for (int k = 1; k <= NUM_SRC; k++) begin
      if (!found && src_valid[(int'(last) + k) % NUM_SRC]) begin
        found = 1'b1;
        grant[(int'(last) + k) % NUM_SRC] = 1'b1;
        win   = LW'((int'(last) + k) % NUM_SRC);
      end
    end
  end

  // The pointer moves only on a real transfer. The reset value NUM_SRC-1
  // gives src0 first priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       last <= LW'(NUM_SRC - 1);
    else if (xfer) last <= win;
  end
`endif

  // Grants are suppressed during reset so that no transfer can be lost.
  assign src_ready = rst ? '0 : grant;
  assign xfer      = |src_ready;

  // The grant is one-hot, so an OR-reduction mux is enough.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_ready[i]) begin
        sel_addr = sel_addr | src_addr[i*AW +: AW];
        sel_data = sel_data | src_data[i*REG_WIDTH +: REG_WIDTH];
      end
    end
  end

  // Scoreboard next state. The set is applied after the clear so that a newly
  // issued instruction keeps ownership of its destination.
  always_comb begin
    pend_next = pending;
    if (rf_we) pend_next[rf_waddr] = 1'b0;
    if (issue_valid && (issue_rd != '0)) pend_next[issue_rd] = 1'b1;
    pend_next[0] = 1'b0;
  end

  // Write stage. A write to x0 is accepted but rf_we stays low.
  // The address and data hold their values when no transfer occurs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      pending  <= '0;
    end else begin
      rf_we   <= xfer && (sel_addr != '0);
      pending <= pend_next;
      if (xfer) begin
        rf_waddr <= sel_addr;
        rf_wdata <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;
  localparam int RW  = 64;
  localparam int RC  = 32;
  localparam int NS  = 3;
  localparam int AW  = 5;
  localparam int W   = 1 + AW + RW;

  logic              clk = 1'b0;
  logic              rst;
  logic [NS-1:0]     src_valid;
  logic [NS*AW-1:0]  src_addr;
  logic [NS*RW-1:0]  src_data;
  logic [NS-1:0]     src_ready;
  logic              issue_valid;
  logic [AW-1:0]     issue_rd;
  logic              rf_we;
  logic [AW-1:0]     rf_waddr;
  logic [RW-1:0]     rf_wdata;
  logic [RC-1:0]     pending;

  rf_wb_arbiter #(.REG_WIDTH(RW), .REG_COUNT(RC), .NUM_SRC(NS)) dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_addr(src_addr), .src_data(src_data),
    .src_ready(src_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pending(pending)
  );

  // clock
  always #5 clk = ~clk;

  // scoreboard state: entries are {we, addr, data}
  logic [W-1:0]  exp_q[$];
  int            n_assert = 0;
  int            n_fail   = 0;
  int            m_last;
  logic [AW-1:0] m_waddr;
  logic [RW-1:0] m_wdata;
  logic          cur_we;
  logic [AW-1:0] cur_waddr;
  logic [RC-1:0] exp_pending;
  logic          keep_valid;
  int            last_gi;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_last      = NS - 1;
    m_waddr     = '0;
    m_wdata     = '0;
    cur_we      = 1'b0;
    cur_waddr   = '0;
    exp_pending = '0;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    src_valid   = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic set_src(input int i, input logic [AW-1:0] a, input logic [RW-1:0] d);
    src_valid[i]         = 1'b1;
    src_addr[i*AW +: AW] = a;
    src_data[i*RW +: RW] = d;
  endtask

  // One clock cycle: predict and check the grant, queue the expected write,
  // then after the edge pop it and compare the write stage and the scoreboard.
  task automatic cycle();
    logic [NS-1:0] eg;
    logic [W-1:0]  e;
    logic [RC-1:0] np;
    logic [AW-1:0] a;
    int gi;
    #1;
    eg = '0;
    gi = -1;
`ifdef RF_WB_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NS; i++)
      if (gi < 0 && src_valid[i]) gi = i;
`else
    for (int k = 1; k <= NS; k++)
      if (gi < 0 && src_valid[(m_last + k) % NS]) gi = (m_last + k) % NS;
`endif
    if (gi >= 0) eg[gi] = 1'b1;
    chk("src_ready", W'(src_ready), W'(eg));
    if (gi >= 0) begin
      a       = src_addr[gi*AW +: AW];
      m_waddr = a;
      m_wdata = src_data[gi*RW +: RW];
      m_last  = gi;
      exp_q.push_back({a != '0, m_waddr, m_wdata});
    end else begin
      exp_q.push_back({1'b0, m_waddr, m_wdata});
    end
    np = exp_pending;
    if (cur_we) np[cur_waddr] = 1'b0;
    if (issue_valid && issue_rd != '0) np[issue_rd] = 1'b1;
    last_gi = gi;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL queue_empty: observed 0 entries expected 1");
    end else begin
      e = exp_q.pop_front();
      chk("rf_we", W'(rf_we), W'(e[W-1]));
      chk("rf_waddr", W'(rf_waddr), W'(e[W-2 -: AW]));
      chk("rf_wdata", W'(rf_wdata), W'(e[RW-1:0]));
      cur_we    = e[W-1];
      cur_waddr = e[W-2 -: AW];
    end
    exp_pending = np;
    chk("pending", W'(pending), W'(exp_pending));
    issue_valid = 1'b0;
    if (gi >= 0 && !keep_valid) src_valid[gi] = 1'b0;
  endtask

  initial begin
    keep_valid = 1'b0;
    src_addr   = '0;
    src_data   = '0;
    last_gi    = -1;
    // reset state: no grants are given during reset, even with a valid request
    rst = 1'b1;
    src_valid = '0;
    issue_valid = 1'b0;
    issue_rd = '0;
    model_reset();
    @(negedge clk);
    src_valid = 3'b111;
    #1;
    chk("reset_ready", W'(src_ready), '0);
    chk("reset_we", W'(rf_we), '0);
    chk("reset_waddr", W'(rf_waddr), '0);
    chk("reset_wdata", W'(rf_wdata), '0);
    chk("reset_pending", W'(pending), '0);
    do_reset();

    // single src0 writeback with a latency check
    set_src(0, 5'd5, 64'hDEAD);
    cycle();
    chk("t1_ready_c0", W'(last_gi), W'(0));
    chk("t1_we_c1", W'(rf_we), W'(1));
    chk("t1_data_c1", W'(rf_wdata), W'(64'hDEAD));
    cycle();
    chk("t1_we_c2", W'(rf_we), W'(0));

    // all three sources held valid for six cycles
    do_reset();
    keep_valid = 1'b1;
    for (int i = 0; i < NS; i++) set_src(i, AW'($urandom_range(1, 31)), {$urandom, $urandom});
    for (int c = 0; c < 6; c++) begin
      cycle();
`ifdef RF_WB_ARB_FIXED_PRIO_EN
      chk("grant_order", W'(last_gi), W'(0));
`else
      chk("grant_order", W'(last_gi), W'(c % NS));
`endif
    end
    keep_valid = 1'b0;
    src_valid  = '0;
    cycle();

    // a write to x0 is granted and then dropped
    set_src(1, 5'd0, 64'h1234);
    cycle();
    chk("x0_granted", W'(last_gi), W'(1));
    chk("x0_we", W'(rf_we), W'(0));
    chk("x0_pending", W'(pending), '0);

    // issue rd7, then src2 writes rd7 three cycles later
    issue_valid = 1'b1; issue_rd = 5'd7;
    cycle();
    chk("p7_set", W'(pending[7]), W'(1));
    cycle();
    cycle();
    set_src(2, 5'd7, {$urandom, $urandom});
    cycle();
    chk("p7_still_set", W'(pending[7]), W'(1));
    cycle();
    chk("p7_cleared", W'(pending[7]), W'(0));

    // a set and a clear of the same register in one cycle: the set wins
    issue_valid = 1'b1; issue_rd = 5'd9;
    cycle();
    set_src(0, 5'd9, 64'h99);
    cycle();
    chk("p9_we", W'(rf_we && rf_waddr == 5'd9), W'(1));
    issue_valid = 1'b1; issue_rd = 5'd9;
    cycle();
    chk("p9_kept", W'(pending[9]), W'(1));
    issue_valid = 1'b1; issue_rd = 5'd0;
    cycle();
    chk("p0_zero", W'(pending[0]), W'(0));

    // build pending = 0x0F00 with a write in flight, then reset asynchronously
    issue_valid = 1'b1; issue_rd = 5'd8;
    cycle();
    issue_valid = 1'b1; issue_rd = 5'd10;
    cycle();
    issue_valid = 1'b1; issue_rd = 5'd11;
    set_src(1, 5'd12, 64'hABC);
    cycle();
    chk("pre_rst_pending", W'(pending), W'(32'h0000_0F00));
    chk("pre_rst_we", W'(rf_we), W'(1));
    src_valid = 3'b101;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_we", W'(rf_we), '0);
    chk("arst_waddr", W'(rf_waddr), '0);
    chk("arst_wdata", W'(rf_wdata), '0);
    chk("arst_pending", W'(pending), '0);
    chk("arst_ready", W'(src_ready), '0);
    do_reset();

    // random traffic with requests held until accepted
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < NS; i++)
        if (!src_valid[i] && $urandom_range(0, 1) == 1)
          set_src(i, AW'($urandom_range(0, 31)), {$urandom, $urandom});
      issue_valid = ($urandom_range(0, 1) == 1);
      issue_rd    = AW'($urandom_range(0, 31));
      cycle();
    end
    src_valid = '0;
    cycle();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
